// File: rtl/c499_key_loader.sv
// Serial key loader for the locked c499 netlist: shifts in a key plus odd parity, commits atomically.
// Optional macro C499_KEY_STICKY_EN: once a good key is committed, further starts are ignored until rst.
module c499_key_loader #(
    parameter int KEY_W = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             key_sen,
    input  logic             key_sdi,
    output logic [KEY_W-1:0] key_out,
    output logic             key_valid,
    output logic             key_err,
    output logic             busy
);
    typedef enum logic [2:0] {IDLE, SHIFT, CHECK, DONE, ERR} state_t;

    state_t             state_reg, state_next;
    logic [KEY_W-1:0]   shadow_reg;
    logic [KEY_W-1:0]   key_out_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic               parity_reg;
    logic               key_valid_reg;
    logic               key_err_reg;
    logic               busy_reg;

    logic               do_start;
    logic               do_shift;
    logic               do_parity;
    logic               do_commit_ok;
    logic               do_commit_bad;

    always_comb begin
        state_next    = state_reg;
        do_start      = 1'b0;
        do_shift      = 1'b0;
        do_parity     = 1'b0;
        do_commit_ok  = 1'b0;
        do_commit_bad = 1'b0;
        case (state_reg)
            IDLE: do_start = start;
            SHIFT: begin
                if (key_sen) begin
                    if (cnt_reg == CNT_W'(KEY_W)) begin
                        do_parity  = 1'b1;
                        state_next = CHECK;
                    end else begin
                        do_shift = 1'b1;
                    end
                end
            end
            CHECK: begin
                // Odd parity across key and parity bit means the load is good.
                if ((^shadow_reg) ^ parity_reg) begin
                    do_commit_ok = 1'b1;
                    state_next   = DONE;
                end else begin
                    do_commit_bad = 1'b1;
                    state_next    = ERR;
                end
            end
`ifdef C499_KEY_STICKY_EN
            DONE: do_start = 1'b0;
`else
            DONE: do_start = start;
`endif
            ERR:  do_start = start;
            default: state_next = IDLE;
        endcase
        if (do_start) begin
            state_next = SHIFT;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            shadow_reg    <= '0;
            cnt_reg       <= '0;
            parity_reg    <= 1'b0;
            key_out_reg   <= '0;
            key_valid_reg <= 1'b0;
            key_err_reg   <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            state_reg <= state_next;
            busy_reg  <= (state_next == SHIFT) || (state_next == CHECK);
            if (do_start) begin
                cnt_reg       <= '0;
                key_valid_reg <= 1'b0;
                key_err_reg   <= 1'b0;
            end
            // LSB-first: the first serial bit ends up in shadow_reg[0].
            if (do_shift) begin
                shadow_reg <= {key_sdi, shadow_reg[KEY_W-1:1]};
                cnt_reg    <= cnt_reg + 1'b1;
            end
            if (do_parity) begin
                parity_reg <= key_sdi;
            end
            if (do_commit_ok) begin
                key_out_reg   <= shadow_reg;
                key_valid_reg <= 1'b1;
            end
            if (do_commit_bad) begin
                key_out_reg   <= '0;
                key_valid_reg <= 1'b0;
                key_err_reg   <= 1'b1;
            end
        end
    end

    assign key_out   = key_out_reg;
    assign key_valid = key_valid_reg;
    assign key_err   = key_err_reg;
    assign busy      = busy_reg;
endmodule

// File: tb/tb_c499_key_loader.sv
// Directed bench for c499_key_loader; honours C499_KEY_STICKY_EN for the reload expectations.
module tb_c499_key_loader;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        key_sen;
    logic        key_sdi;
    logic [31:0] key_out;
    logic        key_valid;
    logic        key_err;
    logic        busy;

    int errors = 0;
    int checks = 0;

    c499_key_loader #(.KEY_W(32), .CNT_W(6)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .key_sen   (key_sen),
        .key_sdi   (key_sdi),
        .key_out   (key_out),
        .key_valid (key_valid),
        .key_err   (key_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Outputs are sampled and inputs driven 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Sends start then 33 serial bits (key LSB first, then parity).
    // toggle: key_sen alternates 1/0. start_bit: re-pulse start alongside that bit (-1 = never).
    // Leaves the DUT in the CHECK cycle; returns the number of cycles spent in SHIFT.
    task automatic send_key(input logic [31:0] key, input logic par, input bit toggle,
                            input int start_bit, output int shift_cycles);
        logic [32:0] bits;
        int i;
        bit phase;
        bits = {par, key};
        i = 0;
        phase = 1'b1;
        shift_cycles = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        while (i < 33 && shift_cycles < 200) begin
            key_sen = toggle ? phase : 1'b1;
            key_sdi = bits[i];
            start = (i == start_bit) && key_sen;
            tick();
            shift_cycles++;
            if (key_sen) i++;
            phase = ~phase;
        end
        start   = 1'b0;
        key_sen = 1'b0;
        key_sdi = 1'b0;
    endtask

    initial begin
        int sc;
        rst = 1'b1; start = 1'b0; key_sen = 1'b0; key_sdi = 1'b0;
        tick(); tick();
        rst = 1'b0;
        check("reset_key_out", key_out, 32'h0);
        check("reset_key_valid", {31'b0, key_valid}, 32'h0);
        check("reset_key_err", {31'b0, key_err}, 32'h0);
        check("reset_busy", {31'b0, busy}, 32'h0);
        $display("step reset: key_out=0x%08h valid=%0b err=%0b busy=%0b", key_out, key_valid, key_err, busy);

        // 1: good load, cycle 34 is CHECK, cycle 35 shows the key
        send_key(32'hA5A50F0F, 1'b1, 1'b0, -1, sc);
        check("t1_shift_cycles", sc, 33);
        check("t1_check_busy", {31'b0, busy}, 32'h1);
        check("t1_check_valid", {31'b0, key_valid}, 32'h0);
        check("t1_check_key_out", key_out, 32'h0);
        tick();
        check("t1_key_out", key_out, 32'hA5A50F0F);
        check("t1_key_valid", {31'b0, key_valid}, 32'h1);
        check("t1_key_err", {31'b0, key_err}, 32'h0);
        check("t1_busy", {31'b0, busy}, 32'h0);
        $display("step t1: key_out=0x%08h valid=%0b err=%0b", key_out, key_valid, key_err);

`ifndef C499_KEY_STICKY_EN
        // 2: same key, wrong parity
        send_key(32'hA5A50F0F, 1'b0, 1'b0, -1, sc);
        tick();
        check("t2_key_err", {31'b0, key_err}, 32'h1);
        check("t2_key_valid", {31'b0, key_valid}, 32'h0);
        check("t2_key_out", key_out, 32'h0);
        $display("step t2: key_out=0x%08h valid=%0b err=%0b", key_out, key_valid, key_err);

        // 3: stalled shifting with key_sen toggling (retry from ERR)
        send_key(32'h00000001, 1'b0, 1'b1, -1, sc);
        check("t3_shift_cycles", sc, 65);
        check("t3_err_cleared", {31'b0, key_err}, 32'h0);
        tick();
        check("t3_key_out", key_out, 32'h00000001);
        check("t3_key_valid", {31'b0, key_valid}, 32'h1);
        $display("step t3: key_out=0x%08h valid=%0b shift_cycles=%0d", key_out, key_valid, sc);
`endif

        // 4: reload; key_out holds the old key during the new load
        rst = 1'b1; tick(); rst = 1'b0;
        send_key(32'hFFFFFFFF, 1'b1, 1'b0, -1, sc);
        tick();
        check("t4_first_key", key_out, 32'hFFFFFFFF);
        start = 1'b1; tick(); start = 1'b0;
`ifdef C499_KEY_STICKY_EN
        check("t4_sticky_valid", {31'b0, key_valid}, 32'h1);
        check("t4_sticky_busy", {31'b0, busy}, 32'h0);
        for (int k = 0; k < 40; k++) begin
            key_sen = 1'b1; key_sdi = k[0]; tick();
        end
        key_sen = 1'b0;
        check("t4_sticky_key", key_out, 32'hFFFFFFFF);
        check("t4_sticky_valid_end", {31'b0, key_valid}, 32'h1);
`else
        check("t4_reload_valid_low", {31'b0, key_valid}, 32'h0);
        check("t4_reload_busy", {31'b0, busy}, 32'h1);
        check("t4_reload_hold", key_out, 32'hFFFFFFFF);
        // Already in SHIFT; restart sequencing from the bit stream by resetting-free path
        begin
            logic [32:0] bits;
            bits = {1'b0, 32'h12345678};
            for (int k = 0; k < 33; k++) begin
                key_sen = 1'b1; key_sdi = bits[k]; tick();
                if (k == 20) check("t4_mid_hold", key_out, 32'hFFFFFFFF);
            end
            key_sen = 1'b0;
        end
        check("t4_check_hold", key_out, 32'hFFFFFFFF);
        tick();
        check("t4_new_key", key_out, 32'h12345678);
        check("t4_new_valid", {31'b0, key_valid}, 32'h1);
`endif
        $display("step t4: key_out=0x%08h valid=%0b", key_out, key_valid);

        // 5: reset after 10 bits, then a good load
        start = 1'b1; tick(); start = 1'b0;
        for (int k = 0; k < 10; k++) begin
            key_sen = 1'b1; key_sdi = 1'b1; tick();
        end
        rst = 1'b1; start = 1'b1; tick(); rst = 1'b0; start = 1'b0; key_sen = 1'b0;
        check("t5_rst_key_out", key_out, 32'h0);
        check("t5_rst_busy", {31'b0, busy}, 32'h0);
        check("t5_rst_valid", {31'b0, key_valid}, 32'h0);
        tick();
        check("t5_idle_busy", {31'b0, busy}, 32'h0);
        send_key(32'hDEADBEEF, 1'b1, 1'b0, -1, sc);
        tick();
        check("t5_key_out", key_out, 32'hDEADBEEF);
        check("t5_key_valid", {31'b0, key_valid}, 32'h1);
        $display("step t5: key_out=0x%08h valid=%0b", key_out, key_valid);

        // 6: start during SHIFT is ignored
        rst = 1'b1; tick(); rst = 1'b0;
        send_key(32'h0F1E2D3C, 1'b1, 1'b0, 5, sc);
        check("t6_shift_cycles", sc, 33);
        tick();
        check("t6_key_out", key_out, 32'h0F1E2D3C);
        check("t6_key_valid", {31'b0, key_valid}, 32'h1);
        check("t6_key_err", {31'b0, key_err}, 32'h0);
        $display("step t6: key_out=0x%08h valid=%0b err=%0b", key_out, key_valid, key_err);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
